// File: rtl/uart_tx_if.sv
// rtl/uart_tx_if.sv - parallel word handshake into the UART transmitter
interface uart_tx_if #(
    parameter int DATA_BITS = 8
) ();
    logic                 tx_valid;
    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_ready;

    modport master (output tx_valid, output tx_data, input tx_ready);
    modport slave  (input tx_valid, input tx_data, output tx_ready);
endinterface

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - UART transmitter, LSB first, optional parity, 1/2 stop bits
module uart_tx #(
    parameter int BAUD_DIV      = 434,
    parameter int DATA_BITS     = 8,
    parameter int ENABLE_PARITY = 1,
    parameter int PARITY_ODD    = 0,
    parameter int STOP_BITS     = 1
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    uart_tx_if.slave   in_if,
    output logic       tx_o,
    output logic       busy_o
);
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    localparam logic [15:0] BAUD_LAST = 16'(BAUD_DIV - 1);
    localparam logic [3:0]  DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0]  STOP_LAST = 4'(STOP_BITS - 1);

    state_t               state_q, state_d;
    logic [15:0]          baud_cnt_q, baud_cnt_d;
    logic [3:0]           bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] hold_q, hold_d;
    logic                 hold_full_q, hold_full_d;
    logic                 parity_q, parity_d;
    logic                 tx_q, tx_d;
    logic                 bit_end;
    logic                 accept;
    logic                 load;

    assign bit_end        = (state_q != IDLE) && (baud_cnt_q == BAUD_LAST);
    assign accept         = in_if.tx_valid && !hold_full_q;
    assign in_if.tx_ready = !hold_full_q;
    assign tx_o           = tx_q;
    assign busy_o         = (state_q != IDLE) || hold_full_q;

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        parity_d   = parity_q;
        bit_cnt_d  = bit_cnt_q;
        load       = 1'b0;
        baud_cnt_d = (state_q == IDLE || bit_end) ? 16'd0 : baud_cnt_q + 16'd1;

        case (state_q)
            IDLE:   load = hold_full_q;
            START:  if (bit_end) state_d = DATA;
            DATA: begin
                if (bit_end) begin
                    shift_d = shift_q >> 1;
                    if (bit_cnt_q == DATA_LAST) begin
                        bit_cnt_d = 4'd0;
                        state_d   = (ENABLE_PARITY != 0) ? PARITY : STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end
            end
            PARITY: if (bit_end) state_d = STOP;
            STOP: begin
                if (bit_end) begin
                    if (bit_cnt_q == STOP_LAST) begin
                        bit_cnt_d = 4'd0;
                        // A pending word chains straight into the next start bit.
                        if (hold_full_q) load = 1'b1;
                        else             state_d = IDLE;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (load) begin
            state_d  = START;
            shift_d  = hold_q;
            parity_d = (^hold_q) ^ (PARITY_ODD != 0);
        end

        hold_d      = accept ? in_if.tx_data : hold_q;
        hold_full_d = load ? 1'b0 : (accept ? 1'b1 : hold_full_q);

        // Line level follows the next state so tx changes on the same edge as the FSM.
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
            PARITY:  tx_d = parity_d;
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            baud_cnt_q  <= 16'd0;
            bit_cnt_q   <= 4'd0;
            shift_q     <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            parity_q    <= 1'b0;
            tx_q        <= 1'b1;
        end else begin
            state_q     <= state_d;
            baud_cnt_q  <= baud_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            parity_q    <= parity_d;
            tx_q        <= tx_d;
        end
    end
endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - self-checking bench for uart_tx against a frame-level model
module tb_uart_tx;
    localparam int       BAUD = 4;
    localparam bit [3:0] PAR  = 4'b0110;
    localparam bit [3:0] ODD  = 4'b0100;
    localparam bit [3:0] STP2 = 4'b1000;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] valid_r;
    logic [7:0] data_r [4];
    logic [3:0] tx_w, busy_w, ready_w;

    int errors = 0;
    int checks = 0;

    int         w_a [$];
    int         w_s [$];
    logic [7:0] w_d [$];
    int         p_edge [$];
    logic [7:0] p_word [$];
    int         n_target;

    always #5 clk = ~clk;

    genvar g;
    generate
        for (g = 0; g < 4; g++) begin : g_dut
            uart_tx_if #(.DATA_BITS(8)) bus ();
            assign bus.tx_valid = valid_r[g];
            assign bus.tx_data  = data_r[g];
            assign ready_w[g]   = bus.tx_ready;
            uart_tx #(
                .BAUD_DIV(BAUD), .DATA_BITS(8),
                .ENABLE_PARITY(PAR[g] ? 1 : 0), .PARITY_ODD(ODD[g] ? 1 : 0),
                .STOP_BITS(STP2[g] ? 2 : 1)
            ) u_dut (
                .clk_i(clk), .rst_ni(rst_n), .in_if(bus.slave),
                .tx_o(tx_w[g]), .busy_o(busy_w[g])
            );
        end
    endgenerate

    function automatic int flen(input int k);
        return BAUD * (10 + int'(PAR[k]) + int'(STP2[k]));
    endfunction

    function automatic logic frame_bit(input int k, input logic [7:0] d, input int idx);
        logic r;
        if (idx == 0)                r = 1'b0;
        else if (idx <= 8)           r = d[idx-1];
        else if (PAR[k] && idx == 9) r = (($countones(d) % 2) == 1) ^ ODD[k];
        else                         r = 1'b1;
        return r;
    endfunction

    function automatic logic exp_tx(input int k, input int e);
        logic r = 1'b1;
        for (int i = 0; i < w_s.size(); i++)
            if (e >= w_s[i] && e < w_s[i] + flen(k)) r = frame_bit(k, w_d[i], (e - w_s[i]) / BAUD);
        return r;
    endfunction

    function automatic logic exp_hold(input int e);
        logic r = 1'b0;
        for (int i = 0; i < w_a.size(); i++)
            if (w_a[i] <= e && e < w_s[i]) r = 1'b1;
        return r;
    endfunction

    function automatic logic exp_busy(input int k, input int e);
        logic r = exp_hold(e);
        for (int i = 0; i < w_s.size(); i++)
            if (e >= w_s[i] && e < w_s[i] + flen(k)) r = 1'b1;
        return r;
    endfunction

    task automatic clear_model();
        w_a.delete(); w_s.delete(); w_d.delete();
        p_edge.delete(); p_word.delete();
        n_target = 0;
    endtask

    // Drive inputs for edge e; mode 0 follows the plan, 1 holds valid high, 2 is random valid.
    task automatic drive(input int k, input int e, input int mode);
        logic       v;
        logic [7:0] d;
        int         s;
        d = 8'($urandom);
        v = 1'b0;
        case (mode)
            0: if (w_a.size() < p_edge.size() && p_edge[w_a.size()] <= e) begin
                   v = 1'b1;
                   d = p_word[w_a.size()];
               end
            1: v = (w_a.size() < n_target);
            default: v = (w_a.size() < n_target) && ($urandom_range(0, 3) == 0);
        endcase
        valid_r    = 4'b0000;
        valid_r[k] = v;
        data_r[k]  = d;
        if (v && !exp_hold(e - 1)) begin
            s = e + 1;
            if (w_s.size() > 0 && w_s[$] + flen(k) > s) s = w_s[$] + flen(k);
            w_a.push_back(e); w_s.push_back(s); w_d.push_back(d);
        end
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        valid_r = 4'b0000;
        for (int k = 0; k < 4; k++) data_r[k] = 8'h00;
        repeat (3) @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            checks += 3;
            if (tx_w[k] !== 1'b1)    begin errors++; $display("FAIL reset_tx dut=%0d got=%b exp=1", k, tx_w[k]); end
            if (busy_w[k] !== 1'b0)  begin errors++; $display("FAIL reset_busy dut=%0d got=%b exp=0", k, busy_w[k]); end
            if (ready_w[k] !== 1'b1) begin errors++; $display("FAIL reset_ready dut=%0d got=%b exp=1", k, ready_w[k]); end
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_frame(input int k, input logic [7:0] word, input string name, output logic par_obs);
        clear_model();
        p_edge.push_back(0); p_word.push_back(word);
        par_obs = 1'bx;
        for (int e = 0; e <= flen(k) + 3; e++) begin
            drive(k, e, 0);
            @(negedge clk);
            if (e == 1 + BAUD * 9 + 1) par_obs = tx_w[k];
            checks += 3;
            if (tx_w[k] !== exp_tx(k, e))      begin errors++; $display("FAIL %s_tx e=%0d got=%b exp=%b", name, e, tx_w[k], exp_tx(k, e)); end
            if (busy_w[k] !== exp_busy(k, e))  begin errors++; $display("FAIL %s_busy e=%0d got=%b exp=%b", name, e, busy_w[k], exp_busy(k, e)); end
            if (ready_w[k] !== !exp_hold(e))   begin errors++; $display("FAIL %s_ready e=%0d got=%b exp=%b", name, e, ready_w[k], !exp_hold(e)); end
        end
        valid_r = 4'b0000;
    endtask

    task automatic test_parity();
        logic p;
        test_frame(1, 8'h03, "par_even", p);
        checks++;
        if (p !== 1'b0) begin errors++; $display("FAIL par_even_bit got=%b exp=0", p); end
        test_frame(2, 8'h03, "par_odd", p);
        checks++;
        if (p !== 1'b1) begin errors++; $display("FAIL par_odd_bit got=%b exp=1", p); end
    endtask

    task automatic test_two_words(input logic [7:0] w0, input logic [7:0] w1, input int e1,
                                  input int gap_edge, input logic gap_tx, input string name);
        clear_model();
        p_edge.push_back(0);  p_word.push_back(w0);
        p_edge.push_back(e1); p_word.push_back(w1);
        for (int e = 0; e <= 2 * flen(0) + 4; e++) begin
            drive(0, e, 0);
            @(negedge clk);
            checks += 3;
            if (tx_w[0] !== exp_tx(0, e))     begin errors++; $display("FAIL %s_tx e=%0d got=%b exp=%b", name, e, tx_w[0], exp_tx(0, e)); end
            if (busy_w[0] !== exp_busy(0, e)) begin errors++; $display("FAIL %s_busy e=%0d got=%b exp=%b", name, e, busy_w[0], exp_busy(0, e)); end
            if (ready_w[0] !== !exp_hold(e))  begin errors++; $display("FAIL %s_ready e=%0d got=%b exp=%b", name, e, ready_w[0], !exp_hold(e)); end
            if (e == gap_edge) begin
                checks++;
                if (tx_w[0] !== gap_tx) begin errors++; $display("FAIL %s_seam e=%0d got=%b exp=%b", name, e, tx_w[0], gap_tx); end
            end
        end
        valid_r = 4'b0000;
    endtask

    task automatic test_back_to_back();
        test_two_words(8'hA5, 8'h3C, 8, 41, 1'b0, "b2b");
    endtask

    task automatic test_stop_boundary();
        test_two_words(8'h81, 8'h7E, 41, 41, 1'b1, "stop_edge");
    endtask

    task automatic test_stream(input int k, input int mode, input int n, input int cycles, input string name);
        clear_model();
        n_target = n;
        for (int e = 0; e <= cycles; e++) begin
            drive(k, e, mode);
            @(negedge clk);
            checks += 3;
            if (tx_w[k] !== exp_tx(k, e))     begin errors++; $display("FAIL %s_tx dut=%0d e=%0d got=%b exp=%b", name, k, e, tx_w[k], exp_tx(k, e)); end
            if (busy_w[k] !== exp_busy(k, e)) begin errors++; $display("FAIL %s_busy dut=%0d e=%0d got=%b exp=%b", name, k, e, busy_w[k], exp_busy(k, e)); end
            if (ready_w[k] !== !exp_hold(e))  begin errors++; $display("FAIL %s_ready dut=%0d e=%0d got=%b exp=%b", name, k, e, ready_w[k], !exp_hold(e)); end
        end
        valid_r = 4'b0000;
        checks++;
        if (busy_w[k] !== 1'b0) begin errors++; $display("FAIL %s_drain dut=%0d got=%b exp=0", name, k, busy_w[k]); end
    endtask

    task automatic test_held_off();
        test_stream(0, 1, 3, 3 * flen(0) + 5, "held_off");
    endtask

    task automatic test_random();
        for (int k = 0; k < 4; k++) test_stream(k, 2, 4, 500, "random");
    endtask

    task automatic test_reset_mid();
        clear_model();
        p_edge.push_back(0); p_word.push_back(8'h5A);
        p_edge.push_back(2); p_word.push_back(8'hC3);
        for (int e = 0; e <= 18; e++) begin
            drive(0, e, 0);
            @(negedge clk);
            checks++;
            if (tx_w[0] !== exp_tx(0, e)) begin errors++; $display("FAIL rst_mid_pre_tx e=%0d got=%b exp=%b", e, tx_w[0], exp_tx(0, e)); end
        end
        valid_r = 4'b0000;
        #2 rst_n = 1'b0;
        #1;
        checks += 3;
        if (tx_w[0] !== 1'b1)    begin errors++; $display("FAIL rst_mid_tx got=%b exp=1", tx_w[0]); end
        if (busy_w[0] !== 1'b0)  begin errors++; $display("FAIL rst_mid_busy got=%b exp=0", busy_w[0]); end
        if (ready_w[0] !== 1'b1) begin errors++; $display("FAIL rst_mid_ready got=%b exp=1", ready_w[0]); end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            checks += 2;
            if (tx_w[0] !== 1'b1)   begin errors++; $display("FAIL rst_mid_post_tx c=%0d got=%b exp=1", c, tx_w[0]); end
            if (busy_w[0] !== 1'b0) begin errors++; $display("FAIL rst_mid_post_busy c=%0d got=%b exp=0", c, busy_w[0]); end
        end
    endtask

    initial begin
        logic p;
        test_reset();
        test_frame(0, 8'h55, "single_8n1", p);
        test_parity();
        test_frame(3, 8'hFF, "two_stop", p);
        test_back_to_back();
        test_stop_boundary();
        test_held_off();
        test_random();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
